// File: rtl/alarm_ringer.sv
// ============================================================================
// Module   : alarm_ringer
// Brief    : Alarm session controller: gated 1 s on / 1 s off buzzer tone with
//            dismiss, auto-timeout and (ALARM_RINGER_SNOOZE_EN) limited snooze.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_ringer #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int TONE_HZ        = 2000,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic alarm_trigger,
  input  logic sec_tick,
  input  logic dismiss_btn,
  input  logic snooze_btn,
  output logic buzzer,
  output logic ringing,
  output logic snoozed
);

  localparam int c_HALF   = CLK_FREQ_HZ / (2 * TONE_HZ);
  localparam int c_DIV_W  = (c_HALF > 1) ? $clog2(c_HALF) : 1;
  localparam int c_RING_W = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
  localparam int c_SNZ_W  = (SNOOZE_S > 1) ? $clog2(SNOOZE_S) : 1;
  localparam int c_USED_W = (MAX_SNOOZES + 1 > 1) ? $clog2(MAX_SNOOZES + 1) : 1;

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(c_HALF - 1);
  localparam logic [c_RING_W-1:0] c_RING_LAST = c_RING_W'(RING_TIMEOUT_S - 1);
  localparam logic [c_SNZ_W-1:0]  c_SNZ_LAST  = c_SNZ_W'(SNOOZE_S - 1);
  localparam logic [c_USED_W-1:0] c_USED_MAX  = c_USED_W'(MAX_SNOOZES);

`ifdef ALARM_RINGER_SNOOZE_EN
  localparam logic c_SNOOZE_EN = 1'b1;
`else
  localparam logic c_SNOOZE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_trg_q, r_dis_q, r_snz_q;
  logic [c_RING_W-1:0] r_ring_cnt, w_ring_nxt;
  logic [c_SNZ_W-1:0]  r_snz_cnt, w_snzc_nxt;
  logic [c_USED_W-1:0] r_used, w_used_nxt;
  logic [c_DIV_W-1:0]  r_div, w_div_nxt;
  logic                r_tone, w_tone_nxt;
  logic                r_gate, w_gate_nxt;
  logic                r_buzzer, w_buz_nxt;
  logic                w_enter_ring;
  logic                w_trg, w_dis, w_snz;

  // Edge regs reset high so a level already asserted at reset release is not an event.
  assign w_trg = alarm_trigger & ~r_trg_q;
  assign w_dis = dismiss_btn & ~r_dis_q;
  assign w_snz = snooze_btn & ~r_snz_q & c_SNOOZE_EN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_trg_q    <= 1'b1;
      r_dis_q    <= 1'b1;
      r_snz_q    <= 1'b1;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_used     <= '0;
      r_div      <= '0;
      r_tone     <= 1'b0;
      r_gate     <= 1'b0;
      r_buzzer   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_trg_q    <= alarm_trigger;
      r_dis_q    <= dismiss_btn;
      r_snz_q    <= snooze_btn;
      r_ring_cnt <= w_ring_nxt;
      r_snz_cnt  <= w_snzc_nxt;
      r_used     <= w_used_nxt;
      r_div      <= w_div_nxt;
      r_tone     <= w_tone_nxt;
      r_gate     <= w_gate_nxt;
      r_buzzer   <= w_buz_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ring_nxt   = r_ring_cnt;
    w_snzc_nxt   = r_snz_cnt;
    w_used_nxt   = r_used;
    w_div_nxt    = r_div;
    w_tone_nxt   = r_tone;
    w_gate_nxt   = r_gate;
    w_enter_ring = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_trg) begin
          w_state_nxt  = ST_RINGING;
          w_enter_ring = 1'b1;
          w_used_nxt   = '0;
        end
      end
      ST_RINGING: begin
        if (w_dis) begin
          w_state_nxt = ST_IDLE;
        end else if (w_snz && (r_used < c_USED_MAX)) begin
          w_state_nxt = ST_SNOOZE;
          w_used_nxt  = r_used + c_USED_W'(1);
          w_snzc_nxt  = '0;
        end else begin
          if (r_div == c_DIV_LAST) begin
            w_div_nxt  = '0;
            w_tone_nxt = ~r_tone;
          end else begin
            w_div_nxt = r_div + c_DIV_W'(1);
          end
          // The final tick ends the session, so the counter never wraps.
          if (sec_tick) begin
            if (r_ring_cnt == c_RING_LAST) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_ring_nxt = r_ring_cnt + c_RING_W'(1);
              w_gate_nxt = ~r_gate;
            end
          end
        end
      end
      ST_SNOOZE: begin
        if (w_dis) begin
          w_state_nxt = ST_IDLE;
        end else if (w_trg) begin
          w_state_nxt  = ST_RINGING;
          w_enter_ring = 1'b1;
          w_used_nxt   = '0;
        end else if (sec_tick) begin
          if (r_snz_cnt == c_SNZ_LAST) begin
            w_state_nxt  = ST_RINGING;
            w_enter_ring = 1'b1;
          end else begin
            w_snzc_nxt = r_snz_cnt + c_SNZ_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_enter_ring) begin
      w_ring_nxt = '0;
      w_gate_nxt = 1'b1;
      w_div_nxt  = '0;
      w_tone_nxt = 1'b0;
    end

    w_buz_nxt = (w_state_nxt == ST_RINGING) & w_tone_nxt & w_gate_nxt;
  end

  assign buzzer  = r_buzzer;
  assign ringing = (r_state == ST_RINGING);

`ifdef ALARM_RINGER_SNOOZE_EN
  assign snoozed = (r_state == ST_SNOOZE);
`else
  assign snoozed = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alarm_ringer.sv
// ============================================================================
// Module   : tb_alarm_ringer
// Brief    : Self-checking bench for alarm_ringer (directed + random stimulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_ringer;

  localparam int CLK_FREQ_HZ    = 1000;
  localparam int TONE_HZ        = 100;
  localparam int RING_TIMEOUT_S = 4;
  localparam int SNOOZE_S       = 3;
  localparam int MAX_SNOOZES    = 2;
  localparam int HALF           = CLK_FREQ_HZ / (2 * TONE_HZ);

`ifdef ALARM_RINGER_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic alarm_trigger = 1'b0;
  logic sec_tick = 1'b0;
  logic dismiss_btn = 1'b0;
  logic snooze_btn = 1'b0;
  logic buzzer, ringing, snoozed;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_ringer #(
    .CLK_FREQ_HZ   (CLK_FREQ_HZ),
    .TONE_HZ       (TONE_HZ),
    .RING_TIMEOUT_S(RING_TIMEOUT_S),
    .SNOOZE_S      (SNOOZE_S),
    .MAX_SNOOZES   (MAX_SNOOZES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alarm_trigger(alarm_trigger),
    .sec_tick     (sec_tick),
    .dismiss_btn  (dismiss_btn),
    .snooze_btn   (snooze_btn),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozed      (snoozed)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 ringing, 2 snoozed. Tone and gate are
  // derived from clock edges and seconds elapsed since the ring started.
  int m_mode = 0;
  int m_edges = 0;
  int m_secs = 0;
  int m_snz_secs = 0;
  int m_used = 0;
  bit p_trg = 1'b1, p_dis = 1'b1, p_snz = 1'b1;

  function automatic void start_ring_model();
    m_mode  = 1;
    m_edges = 0;
    m_secs  = 0;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit trg, dis, snz;
    if (reset) begin
      m_mode = 0; m_edges = 0; m_secs = 0; m_snz_secs = 0; m_used = 0;
      p_trg = 1'b1; p_dis = 1'b1; p_snz = 1'b1;
    end else begin
      trg = alarm_trigger && !p_trg;
      dis = dismiss_btn && !p_dis;
      snz = SNZ_EN && snooze_btn && !p_snz;
      p_trg = alarm_trigger; p_dis = dismiss_btn; p_snz = snooze_btn;
      if (m_mode == 0) begin
        if (trg) begin start_ring_model(); m_used = 0; end
      end else if (m_mode == 1) begin
        if (dis) m_mode = 0;
        else if (snz && m_used < MAX_SNOOZES) begin
          m_mode = 2; m_used++; m_snz_secs = 0;
        end else begin
          m_edges++;
          if (sec_tick) begin
            if (m_secs == RING_TIMEOUT_S - 1) m_mode = 0;
            else m_secs++;
          end
        end
      end else begin
        if (dis) m_mode = 0;
        else if (trg) begin start_ring_model(); m_used = 0; end
        else if (sec_tick) begin
          if (m_snz_secs == SNOOZE_S - 1) start_ring_model();
          else m_snz_secs++;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic e_ring, e_snz, e_buz;
    e_ring = (m_mode == 1);
    e_snz  = (m_mode == 2);
    e_buz  = (m_mode == 1) && (((m_edges / HALF) % 2) == 1) && ((m_secs % 2) == 0);
    cmp("model_ringing", ringing, e_ring);
    cmp("model_snoozed", snoozed, e_snz);
    cmp("model_buzzer", buzzer, e_buz);
  end

  task automatic start_ring();
    alarm_trigger = 1'b0;
    @(negedge clk);
    alarm_trigger = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick_pulse();
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  task automatic press_dismiss();
    dismiss_btn = 1'b1;
    @(negedge clk);
    dismiss_btn = 1'b0;
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1;
    @(negedge clk);
    snooze_btn = 1'b0;
  endtask

  initial begin
    // Trigger held high across reset release must not ring.
    alarm_trigger = 1'b1;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    cmp("reset_ringing", ringing, 1'b0);
    cmp("reset_buzzer", buzzer, 1'b0);
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);
    cmp("held_trigger_no_ring", ringing, 1'b0);

    // Ring pattern and timeout.
    start_ring();
    cmp("t1_ringing", ringing, 1'b1);
    cmp("t1_buzzer_entry", buzzer, 1'b0);
    repeat (4) @(negedge clk);
    cmp("t1_buzzer_before_half", buzzer, 1'b0);
    @(negedge clk);
    cmp("t1_buzzer_first_high", buzzer, 1'b1);
    repeat (5) @(negedge clk);
    cmp("t1_buzzer_low_again", buzzer, 1'b0);
    tick_pulse();
    repeat (5) @(negedge clk);
    cmp("t1_gate_off_silent", buzzer, 1'b0);
    cmp("t1_still_ringing", ringing, 1'b1);
    tick_pulse();
    cmp("t1_gate_on_again", buzzer, 1'b1);
    tick_pulse();
    tick_pulse();
    cmp("t1_timeout_ringing", ringing, 1'b0);
    cmp("t1_timeout_buzzer", buzzer, 1'b0);

    // Dismiss while trigger stays high; then re-raise.
    start_ring();
    press_dismiss();
    cmp("t5_dismissed", ringing, 1'b0);
    repeat (10) @(negedge clk);
    cmp("t5_no_rering", ringing, 1'b0);
    start_ring();
    cmp("t5_rering", ringing, 1'b1);
    press_dismiss();

    // Snooze handling.
    start_ring();
    press_snooze();
`ifdef ALARM_RINGER_SNOOZE_EN
    cmp("t2_snoozed1", snoozed, 1'b1);
    cmp("t2_buzzer_snooze", buzzer, 1'b0);
    repeat (3) tick_pulse();
    cmp("t2_resumed1", ringing, 1'b1);
    press_snooze();
    cmp("t2_snoozed2", snoozed, 1'b1);
    repeat (2) tick_pulse();
    cmp("t2_still_snoozed", snoozed, 1'b1);
    tick_pulse();
    cmp("t2_resumed2", ringing, 1'b1);
    press_snooze();
    cmp("t2_third_ignored_ring", ringing, 1'b1);
    cmp("t2_third_ignored_snz", snoozed, 1'b0);
`else
    cmp("t6_snooze_ignored_ring", ringing, 1'b1);
    cmp("t6_snooze_ignored_snz", snoozed, 1'b0);
    repeat (5) @(negedge clk);
    cmp("t6_snoozed_low", snoozed, 1'b0);
`endif
    press_dismiss();

    // Dismiss and snooze together: dismiss wins.
    start_ring();
    dismiss_btn = 1'b1;
    snooze_btn  = 1'b1;
    @(negedge clk);
    dismiss_btn = 1'b0;
    snooze_btn  = 1'b0;
    cmp("t3_ringing", ringing, 1'b0);
    cmp("t3_snoozed", snoozed, 1'b0);

    // Reset mid-ring drops outputs immediately.
    start_ring();
    repeat (5) @(negedge clk);
    cmp("t4_pre_reset_buzzer", buzzer, 1'b1);
    #2 reset = 1'b1;
    #1;
    cmp("t4_async_buzzer", buzzer, 1'b0);
    cmp("t4_async_ringing", ringing, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    cmp("t4_no_replay", ringing, 1'b0);

    // Randomized phase, checked every cycle by the model.
    repeat (4000) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) alarm_trigger = ~alarm_trigger;
      sec_tick    = ($urandom_range(0, 5) == 0);
      dismiss_btn = ($urandom_range(0, 79) == 0);
      snooze_btn  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
